// File: rtl/ifid_fetch_queue_if.sv
// ifid_fetch_queue_if: fetch-side push and decode-side pop handshakes of the fetch queue
interface ifid_fetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    logic                     in_valid;
    logic [DATA_W-1:0]        in_inst;
    logic [DATA_W-1:0]        in_pc;
    logic                     in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_inst;
    logic [DATA_W-1:0]        out_pc;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, count
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, count
    );
endinterface

// File: rtl/ifid_fetch_queue.sv
// ifid_fetch_queue: in-order fall-through buffer of {inst, pc} between fetch and decode
module ifid_fetch_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input logic               clk,
    input logic               rst,
    input logic               flush,
    ifid_fetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [DATA_W-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              push;
    logic              pop;

    assign bus.in_ready  = cnt != CW'(DEPTH);
    assign bus.out_valid = cnt != '0;
    assign bus.count     = cnt;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Head is read combinationally; an empty queue presents a NOP at pc 0
    always_comb begin
        bus.out_inst = bus.out_valid ? inst_mem[rd_ptr] : '0;
        bus.out_pc   = bus.out_valid ? pc_mem[rd_ptr]   : '0;
    end

    // Pointers and occupancy; reset and flush both empty the queue in one cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Entry storage is unreset; a pair arriving alongside a flush is dropped
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            inst_mem[wr_ptr] <= bus.in_inst;
            pc_mem[wr_ptr]   <= bus.in_pc;
        end
    end
endmodule

// File: tb/tb_ifid_fetch_queue.sv
// tb_ifid_fetch_queue: vector table, corner sequences and random traffic against a queue model
module tb_ifid_fetch_queue;
    logic clk;
    logic rst;
    logic flush;
    int   errors = 0;
    int   checks = 0;
    bit   model_on = 0;
    logic [63:0] q[$];

    ifid_fetch_queue_if #(.DATA_W(32), .DEPTH(4)) bus ();

    ifid_fetch_queue #(.DATA_W(32), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bus(bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        f;
        logic        iv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        ordy;
        logic [2:0]  ec;
        logic        ev;
        logic        er;
        logic [31:0] ei;
        logic [31:0] ep;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 1);
        chk({tag, "_inst"}, bus.out_inst, 0);
        chk({tag, "_pc"}, bus.out_pc, 0);
    endtask

    task automatic apply(input logic r, input logic f, input logic iv,
                         input logic [31:0] inst, input logic [31:0] pc, input logic ordy);
        bit do_push;
        bit do_pop;
        rst = r;
        flush = f;
        bus.in_valid = iv;
        bus.in_inst = inst;
        bus.in_pc = pc;
        bus.out_ready = ordy;
        #1;
        if (model_on) begin
            chk("m_count", 32'(bus.count), 32'(q.size()));
            chk("m_ready", 32'(bus.in_ready), 32'(q.size() != 4));
            chk("m_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            chk("m_inst", bus.out_inst, q.size() != 0 ? q[0][63:32] : 32'h0);
            chk("m_pc", bus.out_pc, q.size() != 0 ? q[0][31:0] : 32'h0);
        end
        do_push = iv && q.size() < 4;
        do_pop = ordy && q.size() > 0;
        @(posedge clk);
        if (r || f) begin
            q.delete();
            if (r) model_on = 1;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({inst, pc});
        end
        #1;
    endtask

    initial begin
        tv[0]  = '{1, 0, 0, 32'h0,  32'h00, 0, 3'd0, 0, 1, 32'h0,  32'h00};
        tv[1]  = '{1, 0, 0, 32'h0,  32'h00, 0, 3'd0, 0, 1, 32'h0,  32'h00};
        tv[2]  = '{0, 0, 0, 32'h0,  32'h00, 0, 3'd0, 0, 1, 32'h0,  32'h00};
        tv[3]  = '{0, 0, 1, 32'hA0, 32'h00, 0, 3'd1, 1, 1, 32'hA0, 32'h00};
        tv[4]  = '{0, 0, 1, 32'hA1, 32'h04, 0, 3'd2, 1, 1, 32'hA0, 32'h00};
        tv[5]  = '{0, 0, 1, 32'hA2, 32'h08, 0, 3'd3, 1, 1, 32'hA0, 32'h00};
        tv[6]  = '{0, 0, 1, 32'hA3, 32'h0C, 0, 3'd4, 1, 0, 32'hA0, 32'h00};
        tv[7]  = '{0, 0, 1, 32'hA4, 32'h10, 0, 3'd4, 1, 0, 32'hA0, 32'h00};
        tv[8]  = '{0, 0, 0, 32'h0,  32'h00, 1, 3'd3, 1, 1, 32'hA1, 32'h04};
        tv[9]  = '{0, 0, 0, 32'h0,  32'h00, 1, 3'd2, 1, 1, 32'hA2, 32'h08};
        tv[10] = '{0, 0, 0, 32'h0,  32'h00, 1, 3'd1, 1, 1, 32'hA3, 32'h0C};
        tv[11] = '{0, 0, 0, 32'h0,  32'h00, 1, 3'd0, 0, 1, 32'h0,  32'h00};

        for (int i = 0; i < 12; i++) begin
            apply(tv[i].r, tv[i].f, tv[i].iv, tv[i].inst, tv[i].pc, tv[i].ordy);
            chk($sformatf("tv%0d_count", i), 32'(bus.count), 32'(tv[i].ec));
            chk($sformatf("tv%0d_valid", i), 32'(bus.out_valid), 32'(tv[i].ev));
            chk($sformatf("tv%0d_ready", i), 32'(bus.in_ready), 32'(tv[i].er));
            chk($sformatf("tv%0d_inst", i), bus.out_inst, tv[i].ei);
            chk($sformatf("tv%0d_pc", i), bus.out_pc, tv[i].ep);
        end

        for (int k = 0; k < 20; k++) begin
            apply(0, 0, 1, 32'hB00 + 32'(k), 32'h100 + 32'(4 * k), 1);
            chk("stream_count", 32'(bus.count), 1);
            chk("stream_pc", bus.out_pc, 32'h100 + 32'(4 * k));
        end
        apply(0, 0, 0, 0, 0, 1);
        chk_empty("stream_drain");

        for (int k = 0; k < 3; k++) apply(0, 0, 1, 32'hC0 + 32'(k), 32'h20 + 32'(4 * k), 0);
        chk("pre_flush_count", 32'(bus.count), 3);
        apply(0, 1, 1, 32'hDEAD, 32'h40, 1);
        chk_empty("flush");
        apply(0, 0, 1, 32'hE0, 32'h80, 0);
        chk("post_flush_count", 32'(bus.count), 1);
        chk("post_flush_pc", bus.out_pc, 32'h80);
        chk("post_flush_inst", bus.out_inst, 32'hE0);
        apply(0, 0, 0, 0, 0, 1);
        chk_empty("post_flush_drain");

        for (int k = 0; k < 4; k++) apply(0, 0, 1, 32'hF0 + 32'(k), 32'h200 + 32'(4 * k), 0);
        chk("full_ready", 32'(bus.in_ready), 0);
        chk("full_count", 32'(bus.count), 4);
        apply(1, 1, 1, 32'h1234, 32'h300, 1);
        chk_empty("rst_flush");
        apply(0, 0, 0, 0, 0, 0);
        chk_empty("rst_flush_idle");

        for (int k = 0; k < 400; k++)
            apply($urandom_range(63) == 0, $urandom_range(15) == 0, 1'($urandom),
                  $urandom, 32'h1000 + 32'(4 * k), 1'($urandom));
        apply(0, 1, 0, 0, 0, 0);
        chk_empty("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
